// File: rtl/pulse_code_seq_pkg.sv
// Shared types and constants for the pulse_code_seq phase-code sequencer.
package pulse_code_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int MIN_DIV      = 2;
    localparam int DEFAULT_DIV  = 1229;
    localparam int MAX_CODE_LEN = 64;

endpackage

// File: rtl/pulse_code_seq_chip_timer.sv
// Chip-period divider: wrap_o is high during the last cycle of each chip period,
// so the sequencer advances on the edge that starts the next chip.
module chip_timer
    import pulse_code_pkg::*;
#(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    input  logic             run_i,
    output logic             wrap_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        cnt_d  = '0;
        wrap_d = 1'b0;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == div_q - DIV_W'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            // div_q is never below 2, so a wrap to 0 can never flag itself
            wrap_d = (cnt_d == div_q - DIV_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            div_q <= div_i;
        end
    end

    assign wrap_o = wrap_q;

endmodule

// File: rtl/pulse_code_seq.sv
// Phase-code sequencer: shifts a latched code out LSB-first, repeated n_rep times.
// Optional macro PULSE_CODE_SEQ_GOLAY_ALT_EN alternates code A / code_b per repetition.
module pulse_code_seq
    import pulse_code_pkg::*;
#(
    parameter int CODE_LEN = 16,
    parameter int DIV_W    = 12,
    parameter int REP_W    = 8,
    parameter int LEN_W    = $clog2(CODE_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_LEN-1:0] code,
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
    input  logic [CODE_LEN-1:0] code_b,
    output logic                code_sel,
`endif
    input  logic [LEN_W-1:0]    code_len,
    input  logic [DIV_W-1:0]    chip_div,
    input  logic [REP_W-1:0]    n_rep,
    output logic                chip,
    output logic                gate,
    output logic                chip_stb,
    output logic [LEN_W-1:0]    chip_idx,
    output logic                busy,
    output logic                done
);

    state_e              state_q;
    logic                chip_q;
    logic                gate_q;
    logic                stb_q;
    logic                busy_q;
    logic                done_q;
    logic [LEN_W-1:0]    idx_q;
    logic [LEN_W-1:0]    len_q;
    logic [REP_W-1:0]    rep_q;
    logic [CODE_LEN-1:0] sh_q;
    logic [CODE_LEN-1:0] code_a_q;

    logic                accept;
    logic                wrap;
    logic                last_chip;
    logic [LEN_W-1:0]    len_eff;
    logic [DIV_W-1:0]    div_eff;
    logic [REP_W-1:0]    rep_eff;
    logic [CODE_LEN-1:0] next_code;

`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
    logic                sel_q;
    logic [CODE_LEN-1:0] code_b_q;

    // sel_q names the code being sent now; the next repetition uses the other one
    assign next_code = sel_q ? code_a_q : code_b_q;
    assign code_sel  = sel_q;
`else
    assign next_code = code_a_q;
`endif

    assign accept    = (state_q == IDLE) && start && !abort;
    assign len_eff   = ((code_len == '0) || (code_len > LEN_W'(CODE_LEN))) ? LEN_W'(CODE_LEN) : code_len;
    assign div_eff   = (chip_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : chip_div;
    assign rep_eff   = (n_rep == '0) ? REP_W'(1) : n_rep;
    assign last_chip = (idx_q == len_q - LEN_W'(1));

    chip_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .div_i  (div_eff),
        .load_i (accept),
        .run_i  (state_q == RUN),
        .wrap_o (wrap)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            code_a_q <= code;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
            code_b_q <= code_b;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            chip_q  <= 1'b0;
            gate_q  <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            sh_q    <= '0;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
            sel_q   <= 1'b0;
`endif
        end else begin
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        gate_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        stb_q   <= 1'b1;
                        chip_q  <= code[0];
                        sh_q    <= code;
                        idx_q   <= '0;
                        len_q   <= len_eff;
                        rep_q   <= rep_eff;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
                        sel_q   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        chip_q  <= 1'b0;
                        idx_q   <= '0;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
                        sel_q   <= 1'b0;
`endif
                    end else if (wrap) begin
                        if (!last_chip) begin
                            stb_q  <= 1'b1;
                            idx_q  <= idx_q + LEN_W'(1);
                            chip_q <= sh_q[1];
                            sh_q   <= sh_q >> 1;
                        end else if (rep_q > REP_W'(1)) begin
                            // seamless restart of the code for the next repetition
                            stb_q  <= 1'b1;
                            rep_q  <= rep_q - REP_W'(1);
                            idx_q  <= '0;
                            chip_q <= next_code[0];
                            sh_q   <= next_code;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
                            sel_q  <= ~sel_q;
`endif
                        end else begin
                            state_q <= FIN;
                            gate_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            chip_q  <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                            rep_q   <= '0;
`ifdef PULSE_CODE_SEQ_GOLAY_ALT_EN
                            sel_q   <= 1'b0;
`endif
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gate_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    chip_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chip     = chip_q;
    assign gate     = gate_q;
    assign chip_stb = stb_q;
    assign chip_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/pulse_code_seq.md
Name: pulse_code_seq

Overview:
- Parametrised phase-code sequencer for the HFSWR transmitter.
- Shifts a binary phase code out LSB-first, one chip per programmable divider period.
- Repeats the code N times per start command and reports busy/done status.
- Sits between the TX timing controller (start/abort) and the BPSK modulator (chip, gate).

Parameters:
- CODE_LEN, 16, maximum code length in chips (2..64).
- DIV_W, 12, width of the chip-period divider.
- REP_W, 8, width of the repetition count.
- LEN_W, $clog2(CODE_LEN+1), derived width of the length and index fields; not overridden.

Ports:
- clk  in  1  system clock, 122.88 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start command.
- abort  in  1  stops the sequence at the next edge.
- code  in  CODE_LEN  code word A; bit 0 is sent first.
- code_len  in  LEN_W  active chips; 0 or >CODE_LEN means CODE_LEN.
- chip_div  in  DIV_W  clock cycles per chip; values <2 are treated as 2. 1229 gives ≈100 kHz.
- n_rep  in  REP_W  code repetitions per start; 0 is treated as 1.
- chip  out  1  current chip value.
- gate  out  1  high while a chip is being emitted.
- chip_stb  out  1  one-cycle pulse on the first cycle of each chip.
- chip_idx  out  LEN_W  index of the current chip.
- busy  out  1  high from the cycle after start until the last chip ends.
- done  out  1  one-cycle pulse after the final chip of the final repetition.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. Outputs chip, gate, chip_stb, busy and done are 0; chip_idx is 0; all counters are 0. Reset overrides everything, mid-sequence included.
- The registered configuration is captured on start. code, code_len, chip_div and n_rep are latched only when start=1 in IDLE. Later input changes have no effect until the next start.
- States: IDLE, RUN, FIN.
- IDLE -> RUN on start & !abort.
  - In the next cycle: gate=1, busy=1, chip_stb=1, chip=code[0], chip_idx=0.
  - First-chip latency is 1 cycle after start.
- Within RUN:
  - The divider counts 0..div-1. Each chip is held for exactly div cycles.
  - When the divider wraps, chip_idx increments, chip_stb pulses and chip updates to the next bit.
- End of code (last chip period ends):
  - If repetitions remain, chip_idx returns to 0 and code[0] is sent on the very next cycle. There is no gap between repetitions.
  - Otherwise go to FIN.
- FIN (1 cycle): gate=0, chip=0, busy=0, done=1. The next state is IDLE.
- Total duration: gate stays high for exactly len*div*reps cycles.
- Start while busy (RUN or FIN) is ignored.
- Abort in RUN or FIN: at the next edge go to IDLE. gate, chip and busy go to 0 and no done pulse is produced.
- Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- When gate=0, chip is forced to 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Counter rules:
  - The divider counter is DIV_W bits wide.
  - The repetition counter is REP_W bits wide and counts down from the latched reps to 1.
  - Overflow is impossible within the clamp rules above.

Optional Feature:
- Macro PULSE_CODE_SEQ_GOLAY_ALT_EN.
- Defined:
  - An extra input port code_b (CODE_LEN) and an extra output port code_sel (1) are added.
  - Both codes are latched on start.
  - Repetitions alternate A, B, A, B…, starting with A. code_sel=0 while code A is sent and 1 while code B is sent; it reads 0 outside RUN.
  - This supports complementary Golay pairs.
- Undefined: the ports are absent and only code A is ever sent.

Decomposition:
- Package pulse_code_pkg contains:
  - the state enum (IDLE, RUN, FIN);
  - the constants MIN_DIV=2, DEFAULT_DIV=1229 and MAX_CODE_LEN=64.
- One sub-module, chip_timer:
  - Inputs: the divider value, a load signal and a run enable.
  - Outputs: a wrap strobe, registered.
- The top level holds the FSM, the chip-index counter, the repetition counter and the code shift/select logic.

Test Plan:
- Reset is asserted mid-RUN with code=16'hB38F, len=16, div=1229, rep=1 -> next cycle gate=0, busy=0, chip=0, chip_idx=0; no done pulse.
- Basic sequence: code=16'h0005, len=4, div=3, rep=1, start -> starting 1 cycle later, chip reads 1,1,1,0,0,0,1,1,1,0,0,0; gate high for 12 cycles; 4 chip_stb pulses; done on cycle 13.
- Repeats and clamps: code=3'b110, len=3, div=1 (clamped to 2), rep=0 (clamped to 1) -> chip reads 0,0,1,1,1,1 then done. A second run with rep=3 gives 18 gate cycles with no gap at the repetition boundaries.
- Abort and re-start: abort at cycle 5 of a div=4, len=8 run -> IDLE next cycle with no done pulse. A start pulse while busy has no effect, and busy stays high.
- Length field: code_len=0 with CODE_LEN=16 and div=2 -> 32 gate cycles; chip_idx reaches 15 and then done fires.
- With PULSE_CODE_SEQ_GOLAY_ALT_EN: code=4'b0111, code_b=4'b1011, len=4, div=2, rep=2 -> chip reads 1,1,1,1,1,1,0,0 then 1,1,1,1,0,0,1,1; code_sel is 0 for 8 cycles and then 1 for 8 cycles.
